// File: rtl/fc_neuron_mac.sv
// fc_neuron_mac: time-multiplexed signed dot product, LANES products per beat,
// with optional ReLU on the accumulated result and valid/ready on both sides.
module fc_neuron_mac #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IN    = 128,
  parameter int unsigned LANES = 4,
  localparam int unsigned OW   = 2 * WIDTH + $clog2(IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] x [0:LANES-1],
  input  logic signed [WIDTH-1:0] w [0:LANES-1],
  input  logic                    relu_en,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [OW-1:0]    z,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned BEATS = (IN + LANES - 1) / LANES;
  localparam int unsigned BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BCW-1:0] LAST_BEAT  = BCW'(BEATS - 1);
  localparam logic [1:0]     FLUSH_LAST = 2'd2;

  typedef enum logic [1:0] {
    ST_ACCUM,
    ST_FLUSH,
    ST_OUT
  } state_t;

  state_t state;
  state_t state_next;

  logic [BCW-1:0]       beat_cnt;
  logic [1:0]           flush_cnt;
  logic                 relu_q;

  logic                 accept_c;
  logic                 handshake_c;
  logic                 last_beat_c;
  logic                 first_beat_c;
  logic                 load_z_c;

  logic signed [PW-1:0] prod_c [0:LANES-1];
  logic signed [PW-1:0] prod_q [0:LANES-1];
  logic                 p_valid;
  logic                 p_first;
  logic signed [OW-1:0] lane_sum_c;
  logic signed [OW-1:0] acc;

  assign accept_c     = in_valid && in_ready;
  assign handshake_c  = out_valid && out_ready;
  assign last_beat_c  = (beat_cnt == LAST_BEAT);
  assign first_beat_c = (beat_cnt == '0);
  // S1-S2 need two flush cycles to settle acc; the third edge registers z.
  assign load_z_c     = (state == ST_FLUSH) && (flush_cnt == FLUSH_LAST);

  // Full-width signed products; lanes past the end of the vector contribute zero.
  always_comb begin
    for (int l = 0; l < int'(LANES); l++) begin
      prod_c[l] = '0;
      if ((int'(beat_cnt) * int'(LANES) + l) < int'(IN)) begin
        prod_c[l] = PW'(x[l]) * PW'(w[l]);
      end
    end
  end

  // Sign-extended sum of the registered lane products.
  always_comb begin
    lane_sum_c = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      lane_sum_c = lane_sum_c + OW'(prod_q[l]);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ACCUM;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_ACCUM: if (accept_c && last_beat_c) state_next = ST_FLUSH;
      ST_FLUSH: if (flush_cnt == FLUSH_LAST) state_next = ST_OUT;
      ST_OUT:   if (handshake_c) state_next = ST_ACCUM;
      default:  state_next = ST_ACCUM;
    endcase
  end

  // Registered handshake outputs, beat/flush counters and captured ReLU mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      relu_q    <= 1'b0;
    end else begin
      in_ready  <= (state_next == ST_ACCUM);
      out_valid <= (state_next == ST_OUT);
      flush_cnt <= (state == ST_FLUSH) ? flush_cnt + 2'd1 : 2'd0;
      if (accept_c) begin
        beat_cnt <= last_beat_c ? '0 : beat_cnt + BCW'(1);
        if (first_beat_c) begin
          relu_q <= relu_en;
        end
      end
    end
  end

  // S1: register masked products of each accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < int'(LANES); l++) begin
        prod_q[l] <= '0;
      end
      p_valid <= 1'b0;
      p_first <= 1'b0;
    end else begin
      p_valid <= accept_c;
      p_first <= accept_c && first_beat_c;
      if (accept_c) begin
        prod_q <= prod_c;
      end
    end
  end

  // S2: accumulate; beat 0 starts from zero, the output handshake clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (handshake_c) begin
      acc <= '0;
    end else if (p_valid) begin
      acc <= (p_first ? OW'(0) : acc) + lane_sum_c;
    end
  end

  // S3: register the result with optional ReLU when entering OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z <= '0;
    end else if (load_z_c) begin
      z <= (relu_q && acc[OW-1]) ? OW'(0) : acc;
    end
  end

endmodule

// File: tb/tb_fc_neuron_mac.sv
// Bench for fc_neuron_mac: three instances (IN=8, 128, 10; LANES=4) driven by
// directed and random vectors, checked against a plain dot-product model.
module tb_fc_neuron_mac;

  localparam int L     = 4;
  localparam int D8    = 0;
  localparam int D128  = 1;
  localparam int D10   = 2;
  localparam int TMO   = 5000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic signed [7:0] x [0:L-1];
  logic signed [7:0] w [0:L-1];
  logic              relu_en;
  logic              iv   [0:2];
  logic              ordy [0:2];

  logic rdy0, rdy1, rdy2;
  logic ov0, ov1, ov2;
  logic signed [18:0] z8;
  logic signed [22:0] z128;
  logic signed [19:0] z10;

  fc_neuron_mac #(.WIDTH(8), .IN(8), .LANES(4)) u_d8 (
    .clk(clk), .rst_n(rst_n), .x(x), .w(w), .relu_en(relu_en),
    .in_valid(iv[0]), .in_ready(rdy0), .z(z8), .out_valid(ov0), .out_ready(ordy[0])
  );

  fc_neuron_mac #(.WIDTH(8), .IN(128), .LANES(4)) u_d128 (
    .clk(clk), .rst_n(rst_n), .x(x), .w(w), .relu_en(relu_en),
    .in_valid(iv[1]), .in_ready(rdy1), .z(z128), .out_valid(ov1), .out_ready(ordy[1])
  );

  fc_neuron_mac #(.WIDTH(8), .IN(10), .LANES(4)) u_d10 (
    .clk(clk), .rst_n(rst_n), .x(x), .w(w), .relu_en(relu_en),
    .in_valid(iv[2]), .in_ready(rdy2), .z(z10), .out_valid(ov2), .out_ready(ordy[2])
  );

  int n_checks = 0;
  int n_fail   = 0;
  int vx [128];
  int vw [128];

  function automatic logic get_rdy(int sel);
    case (sel)
      D8:      return rdy0;
      D128:    return rdy1;
      default: return rdy2;
    endcase
  endfunction

  function automatic logic get_ov(int sel);
    case (sel)
      D8:      return ov0;
      D128:    return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic logic signed [63:0] get_z(int sel);
    case (sel)
      D8:      return 64'(z8);
      D128:    return 64'(z128);
      default: return 64'(z10);
    endcase
  endfunction

  function automatic int vec_len(int sel);
    case (sel)
      D8:      return 8;
      D128:    return 128;
      default: return 10;
    endcase
  endfunction

  // Reference: plain dot product of the first n elements, then optional ReLU.
  function automatic longint ref_dot(int n, bit relu);
    longint s = 0;
    for (int i = 0; i < n; i++) s += longint'(vx[i]) * longint'(vw[i]);
    if (relu && s < 0) s = 0;
    return s;
  endfunction

  task automatic check(string tag, logic signed [63:0] got, logic signed [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill_const(int n, int xv, int wv);
    for (int i = 0; i < n; i++) begin
      vx[i] = xv;
      vw[i] = wv;
    end
  endtask

  task automatic fill_rand(int n);
    for (int i = 0; i < n; i++) begin
      vx[i] = int'($urandom_range(0, 255)) - 128;
      vw[i] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  // Present beats of vx/vw until `stop` beats are accepted; masked lanes carry 127.
  task automatic send_vec(int sel, bit relu, bit gaps, int stop);
    int n = vec_len(sel);
    int beats = (n + L - 1) / L;
    int b = 0;
    int guard = 0;
    bit take;
    while (b < beats && b < stop && guard < TMO) begin
      iv[sel] = gaps ? 1'($urandom) : 1'b1;
      for (int l = 0; l < L; l++) begin
        int idx = b * L + l;
        if (!iv[sel]) begin
          x[l] = 8'($urandom);
          w[l] = 8'($urandom);
        end else if (idx < n) begin
          x[l] = 8'(vx[idx]);
          w[l] = 8'(vw[idx]);
        end else begin
          x[l] = 8'sd127;
          w[l] = 8'sd127;
        end
      end
      relu_en = (b == 0 && iv[sel]) ? relu : 1'($urandom);
      take = iv[sel] && get_rdy(sel);
      @(posedge clk); #1;
      if (take) b++;
      guard++;
    end
    iv[sel] = 1'b0;
    relu_en = 1'($urandom);
    for (int l = 0; l < L; l++) begin
      x[l] = 8'($urandom);
      w[l] = 8'($urandom);
    end
    if (guard >= TMO) check("send_timeout", 0, 1);
  endtask

  // Called right after the edge that accepted the last beat.
  task automatic check_latency(int sel);
    @(posedge clk); #1;
    check("lat_e1_valid", 64'(get_ov(sel)), 0);
    check("lat_e1_ready", 64'(get_rdy(sel)), 0);
    @(posedge clk); #1;
    check("lat_e2_valid", 64'(get_ov(sel)), 0);
    @(posedge clk); #1;
    check("lat_e3_valid", 64'(get_ov(sel)), 1);
    check("lat_e3_ready", 64'(get_rdy(sel)), 0);
  endtask

  // Wait for the result, check it, optionally stall out_ready, then consume.
  task automatic recv(int sel, longint expv, int hold);
    int guard = 0;
    while (!get_ov(sel) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("out_valid_seen", 64'(get_ov(sel)), 1);
    check("z", get_z(sel), expv);
    if (hold > 0) begin
      ordy[sel] = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check("hold_valid", 64'(get_ov(sel)), 1);
        check("hold_z", get_z(sel), expv);
        check("hold_ready", 64'(get_rdy(sel)), 0);
      end
    end
    ordy[sel] = 1'b1;
    @(posedge clk); #1;
    ordy[sel] = 1'b0;
    check("post_hs_valid", 64'(get_ov(sel)), 0);
    check("post_hs_ready", 64'(get_rdy(sel)), 1);
  endtask

  initial begin
    longint e;
    bit r;

    // Reset state.
    rst_n   = 1'b0;
    relu_en = 1'b0;
    for (int s = 0; s < 3; s++) begin
      iv[s]   = 1'b0;
      ordy[s] = 1'b0;
    end
    for (int l = 0; l < L; l++) begin
      x[l] = '0;
      w[l] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check("rst_ready", 64'(get_rdy(s)), 0);
      check("rst_valid", 64'(get_ov(s)), 0);
      check("rst_z", get_z(s), 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int s = 0; s < 3; s++) check("rst_ready_rise", 64'(get_rdy(s)), 1);

    // IN=8, all ones, continuous beats.
    fill_const(8, 1, 1);
    send_vec(D8, 1'b0, 1'b0, 1000);
    check_latency(D8);
    recv(D8, 8, 0);

    // IN=128 extremes.
    fill_const(128, -128, -128);
    send_vec(D128, 1'b0, 1'b0, 1000);
    check_latency(D128);
    recv(D128, 64'sd2097152, 0);

    fill_const(128, -128, 127);
    send_vec(D128, 1'b0, 1'b0, 1000);
    check_latency(D128);
    recv(D128, -64'sd2080768, 0);

    // Reset after two of 32 beats; z still holds the previous result here.
    fill_rand(128);
    send_vec(D128, 1'b1, 1'b0, 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(ov1), 0);
    check("midrst_z", get_z(D128), 0);
    check("midrst_ready", 64'(rdy1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready_rise", 64'(rdy1), 1);
    fill_rand(128);
    send_vec(D128, 1'b0, 1'b0, 1000);
    check_latency(D128);
    recv(D128, ref_dot(128, 1'b0), 0);

    fill_const(128, -128, 127);
    send_vec(D128, 1'b1, 1'b0, 1000);
    check_latency(D128);
    recv(D128, 0, 0);

    // IN=10: masked lanes of the last beat carry 127*127.
    fill_const(10, 1, 1);
    send_vec(D10, 1'b0, 1'b0, 1000);
    check_latency(D10);
    recv(D10, 10, 0);

    // Back-to-back vectors with ReLU toggled and a stalled first output.
    fill_const(8, -3, 5);
    send_vec(D8, 1'b0, 1'b0, 1000);
    recv(D8, -120, 5);
    send_vec(D8, 1'b1, 1'b0, 1000);
    recv(D8, 0, 0);
    fill_const(8, 2, 3);
    ordy[D8] = 1'b1;
    send_vec(D8, 1'b0, 1'b0, 1000);
    check_latency(D8);
    recv(D8, 48, 0);

    // Random vectors with 50% in_valid gaps.
    for (int k = 0; k < 200; k++) begin
      fill_rand(10);
      r = 1'($urandom);
      e = ref_dot(10, r);
      send_vec(D10, r, 1'b1, 1000);
      recv(D10, e, int'($urandom_range(0, 2)));
    end
    for (int k = 0; k < 4; k++) begin
      fill_rand(128);
      r = 1'($urandom);
      e = ref_dot(128, r);
      send_vec(D128, r, 1'b1, 1000);
      recv(D128, e, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
